wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Capture buffer at the writeback end of the ARM pipeline. Each retired register write presented by the writeback stage is recorded with its PC, destination register, result and a cycle stamp, then drained in order through a valid/ready read port. The bench and debug logic read it to check pipeline results without probing pipeline internals. It is a first-word-fall-through FIFO with overflow accounting.

## Interface
- DEPTH, 16, number of trace entries; power of two, at least 2
- CW, $clog2(DEPTH)+1, width of the `count` output (derived, do not override)

- clk  in  1  pipeline clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wb_valid  in  1  writeback stage retires a register write this cycle
- wb_pc  in  32  PC of the retiring instruction
- wb_rd  in  4  destination register r0–r15
- wb_data  in  32  value written to wb_rd
- trace_ready  in  1  reader accepts the head entry this cycle
- clr_overflow  in  1  clears `overflow` and `drop_count`
- trace_valid  out  1  head entry present
- trace_pc  out  32  head entry PC
- trace_rd  out  4  head entry destination register
- trace_data  out  32  head entry result
- trace_stamp  out  16  head entry cycle stamp
- count  out  CW  entries held, 0..DEPTH
- overflow  out  1  sticky; set when a push is dropped
- drop_count  out  16  dropped pushes, saturating

## Operation
- Storage: DEPTH × 84-bit entries {pc, rd, data, stamp}, with write and read pointers of log2(DEPTH) bits that wrap modulo DEPTH. `count` is a registered occupancy value.
- Stamp counter: 16-bit, free-running, increments every cycle, wraps from 0xFFFF to 0x0000. A pushed entry captures the counter value before that edge's increment.
- Push: on an edge with wb_valid=1.
  - If count<DEPTH, or a pop happens on the same edge, the entry is written at the write pointer and the write pointer advances.
  - Otherwise the push is dropped: overflow←1, drop_count←drop_count+1, saturating at 0xFFFF.
- Pop: on an edge with trace_valid=1 and trace_ready=1. The read pointer advances.
- Count update: push only → +1. Pop only → −1. Both → unchanged.
- Head outputs: trace_valid = (count≠0). trace_pc/rd/data/stamp are driven combinationally from the entry at the read pointer. Their value is don't-care while trace_valid=0.
- Simultaneous push and pop:
  - When full, the push is accepted and count stays at DEPTH.
  - When empty, trace_valid is 0, so no pop occurs and the pushed entry becomes the head.
- clr_overflow=1 on an edge: overflow←0, drop_count←0. If a drop happens on the same edge, the drop wins: overflow=1, drop_count=1.
- Reset (asserted at any time, including mid-drain): immediately clears pointers, count, the stamp counter, overflow and drop_count. trace_valid falls without waiting for a clock edge. Memory contents are not reset. The first push after reset carries stamp 0 if it occurs on the first edge after release.

## Timing
- Push-to-visible latency is 1 cycle: an entry pushed at edge N gives trace_valid=1 and its head fields after edge N.
- Pop takes effect at the edge. The next entry, or trace_valid=0, appears after that edge.
- Full throughput is one push and one pop per cycle, with no bubbles.
- Reset values: trace_valid=0, count=0, overflow=0, drop_count=0, stamp counter=0. trace_pc/rd/data/stamp are don't-care.
- No combinational path from trace_ready or wb_* to any output. trace_valid depends only on registered count.

## Test plan
- Reset release, then a single push with wb_pc=0x00000008, wb_rd=3, wb_data=0xDEADBEEF on the first edge. After that edge: trace_valid=1, count=1, trace_stamp=0x0000, and the head fields match. Pop with trace_ready=1 → trace_valid=0 and count=0.
- Push 16 entries (DEPTH=16) with data 0..15, trace_ready=0. Push a 17th with data 0x99 → count=16, overflow=1, drop_count=1. Drain all 16 → data reads 0..15 in order and 0x99 is never seen.
- With the buffer full, push and pop on the same edge → count stays 16, the popped entry is data 0, and the new entry appears last after draining.
- Streaming: wb_valid=1 and trace_ready=1 for 100 cycles → count stays at 1. Stamps increment by 1 per entry and wrap from 0xFFFF to 0x0000 once the counter passes 65535 cycles.
- With overflow=1, assert clr_overflow on the same edge as a dropped push → overflow=1, drop_count=1. Assert clr_overflow alone on the next edge → both cleared. Force 70000 drops → drop_count=0xFFFF.
- Assert rst_n=0 mid-cycle with count=5 → trace_valid and count drop to 0 before the next edge. After release, a new push is read back correctly with stamp 0.

Source files
------------

// File: rtl/wb_trace_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : wb_trace_buffer_if
// Purpose  : Bus bundle for the writeback trace buffer: writeback push side,
//            reader drain side and overflow accounting status.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface wb_trace_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wb_valid;
  logic [31:0]   wb_pc;
  logic [3:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          trace_ready;
  logic          clr_overflow;
  logic          trace_valid;
  logic [31:0]   trace_pc;
  logic [3:0]    trace_rd;
  logic [31:0]   trace_data;
  logic [15:0]   trace_stamp;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   drop_count;

  // Writeback stage and reader side
  modport master (
    output wb_valid, wb_pc, wb_rd, wb_data, trace_ready, clr_overflow,
    input  trace_valid, trace_pc, trace_rd, trace_data, trace_stamp,
           count, overflow, drop_count
  );

  // Trace buffer side
  modport slave (
    input  wb_valid, wb_pc, wb_rd, wb_data, trace_ready, clr_overflow,
    output trace_valid, trace_pc, trace_rd, trace_data, trace_stamp,
           count, overflow, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/wb_trace_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : wb_trace_buffer
// Purpose  : First-word-fall-through capture FIFO for retired register writes
//            {pc, rd, data, stamp}, with sticky overflow and a saturating
//            dropped-push counter.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module wb_trace_buffer #(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_trace_buffer_if.slave bus
);
  localparam int            AW         = $clog2(DEPTH);
  localparam int            CW         = $clog2(DEPTH) + 1;
  localparam int            EW         = 84;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   stamp_q, stamp_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic          do_pop, do_push, do_drop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_entry;

  // Handshake decode: a pop frees a slot on the same edge, so a full buffer
  // can still accept a push when the reader is taking the head.
  always_comb begin
    do_pop   = (count_q != '0) && bus.trace_ready;
    do_push  = bus.wb_valid && ((count_q != FULL_COUNT) || do_pop);
    do_drop  = bus.wb_valid && !do_push;
    wr_entry = {bus.wb_pc, bus.wb_rd, bus.wb_data, stamp_q};
  end

  // Next-state for pointers, occupancy, stamp and overflow accounting
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    stamp_d      = stamp_q + 16'd1;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);

    // A drop on the clearing edge wins: it leaves exactly one drop recorded.
    if (do_drop) begin
      overflow_d = 1'b1;
      if (bus.clr_overflow)              drop_count_d = 16'd1;
      else if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end else if (bus.clr_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = 16'd0;
    end
  end

  // Control state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      stamp_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      stamp_q      <= stamp_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Entry storage; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head_entry      = mem_q[rd_ptr_q];
  assign bus.trace_valid = (count_q != '0);
  assign bus.trace_pc    = head_entry[83:52];
  assign bus.trace_rd    = head_entry[51:48];
  assign bus.trace_data  = head_entry[47:16];
  assign bus.trace_stamp = head_entry[15:0];
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.drop_count  = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_wb_trace_buffer
// Purpose  : Self-checking bench for wb_trace_buffer: queue-based reference
//            model compared every cycle, plus directed literal checks.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_wb_trace_buffer;
  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  rd;
    logic [31:0] data;
    logic [15:0] stamp;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  wb_trace_buffer_if #(.DEPTH(DEPTH)) bus ();

  wb_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  ent_t        mq[$];
  logic [15:0] m_stamp = '0;
  logic        m_ovf   = 1'b0;
  logic [15:0] m_dc    = '0;
  int          m_drops = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    bus.wb_pc   = $urandom;
    bus.wb_rd   = 4'($urandom);
    bus.wb_data = $urandom;
  endtask

  // Reference model: a queue of entries updated from the rules on each edge
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_stamp = '0;
        m_ovf   = 1'b0;
        m_dc    = '0;
        m_drops = 0;
      end else begin
        bit pop, acc, drop;
        ent_t e;
        pop  = (mq.size() != 0) && bus.trace_ready;
        acc  = bus.wb_valid && ((mq.size() < DEPTH) || pop);
        drop = bus.wb_valid && !acc;
        if (pop) void'(mq.pop_front());
        if (acc) begin
          e.pc = bus.wb_pc; e.rd = bus.wb_rd; e.data = bus.wb_data; e.stamp = m_stamp;
          mq.push_back(e);
        end
        if (drop) begin
          m_ovf = 1'b1;
          if (bus.clr_overflow)      m_dc = 16'd1;
          else if (m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
        end else if (bus.clr_overflow) begin
          m_ovf = 1'b0;
          m_dc  = '0;
        end
        if (bus.clr_overflow) m_drops = 0;
        if (drop) m_drops++;
        m_stamp = m_stamp + 16'd1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("trace_valid", 32'(bus.trace_valid), 32'(mq.size() != 0));
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("drop_count", 32'(bus.drop_count), 32'(m_dc));
      if (mq.size() != 0) begin
        chk("trace_pc", bus.trace_pc, mq[0].pc);
        chk("trace_rd", 32'(bus.trace_rd), 32'(mq[0].rd));
        chk("trace_data", bus.trace_data, mq[0].data);
        chk("trace_stamp", 32'(bus.trace_stamp), 32'(mq[0].stamp));
      end
    end
  end

  // Directed and randomized stimulus
  initial begin
    logic [31:0] exp_drain [16];
    logic [15:0] prev_stamp;
    bit          wrap_seen;

    bus.wb_valid = 1'b0; bus.wb_pc = '0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.trace_ready = 1'b0; bus.clr_overflow = 1'b0;
    repeat (3) tick();
    chk("reset_valid", 32'(bus.trace_valid), 32'd0);
    chk("reset_count", 32'(bus.count), 32'd0);

    // First push on the first edge after release
    rst_n = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_pc = 32'h8; bus.wb_rd = 4'd3; bus.wb_data = 32'hDEADBEEF;
    tick();
    chk("first_valid", 32'(bus.trace_valid), 32'd1);
    chk("first_count", 32'(bus.count), 32'd1);
    chk("first_stamp", 32'(bus.trace_stamp), 32'h0);
    chk("first_pc", bus.trace_pc, 32'h8);
    chk("first_rd", 32'(bus.trace_rd), 32'd3);
    chk("first_data", bus.trace_data, 32'hDEADBEEF);
    bus.wb_valid = 1'b0; bus.trace_ready = 1'b1;
    tick();
    chk("pop_valid", 32'(bus.trace_valid), 32'd0);
    chk("pop_count", 32'(bus.count), 32'd0);

    // Fill, then one dropped push
    bus.trace_ready = 1'b0; bus.wb_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rand_fields(); bus.wb_data = 32'(i);
      tick();
    end
    rand_fields(); bus.wb_data = 32'h99;
    tick();
    chk("full_count", 32'(bus.count), 32'd16);
    chk("full_ovf", 32'(bus.overflow), 32'd1);
    chk("full_drops", 32'(bus.drop_count), 32'd1);

    // Push and pop together while full
    rand_fields(); bus.wb_data = 32'hAA; bus.trace_ready = 1'b1;
    chk("fullpp_head", bus.trace_data, 32'd0);
    tick();
    chk("fullpp_count", 32'(bus.count), 32'd16);

    bus.wb_valid = 1'b0;
    for (int i = 0; i < 15; i++) exp_drain[i] = 32'(i + 1);
    exp_drain[15] = 32'hAA;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", bus.trace_data, exp_drain[i]);
      tick();
    end
    chk("drained_valid", 32'(bus.trace_valid), 32'd0);

    // Overflow clear interaction
    bus.trace_ready = 1'b0; bus.wb_valid = 1'b1;
    repeat (16) begin rand_fields(); tick(); end
    rand_fields(); tick();
    chk("drop2", 32'(bus.drop_count), 32'd2);
    bus.clr_overflow = 1'b1; rand_fields();
    tick();
    chk("clrdrop_ovf", 32'(bus.overflow), 32'd1);
    chk("clrdrop_dc", 32'(bus.drop_count), 32'd1);
    bus.wb_valid = 1'b0;
    tick();
    bus.clr_overflow = 1'b0;
    chk("clr_ovf", 32'(bus.overflow), 32'd0);
    chk("clr_dc", 32'(bus.drop_count), 32'd0);

    // Drop while full until the stamp counter nears its wrap
    bus.wb_valid = 1'b1;
    while (m_stamp != 16'hFFCE) begin rand_fields(); tick(); end
    bus.wb_valid = 1'b0; bus.trace_ready = 1'b1;
    repeat (16) tick();

    // Streaming across the stamp wrap
    bus.wb_valid = 1'b1;
    wrap_seen = 1'b0;
    prev_stamp = '0;
    for (int i = 0; i < 100; i++) begin
      rand_fields();
      tick();
      chk("stream_count", 32'(bus.count), 32'd1);
      if (i > 0) begin
        chk("stream_stamp", 32'(bus.trace_stamp), 32'(16'(prev_stamp + 16'd1)));
        if (prev_stamp == 16'hFFFF && bus.trace_stamp == 16'h0000) wrap_seen = 1'b1;
      end
      prev_stamp = bus.trace_stamp;
    end
    chk("stamp_wrap", 32'(wrap_seen), 32'd1);

    // Keep dropping until 70000 drops since the clear
    bus.trace_ready = 1'b0;
    while (m_drops < 70000) begin rand_fields(); tick(); end
    chk("sat_dc", 32'(bus.drop_count), 32'hFFFF);
    chk("sat_ovf", 32'(bus.overflow), 32'd1);

    // Leave five entries, then reset mid-cycle
    bus.wb_valid = 1'b0; bus.trace_ready = 1'b1;
    repeat (11) tick();
    chk("pre_rst_count", 32'(bus.count), 32'd5);
    bus.trace_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(bus.trace_valid), 32'd0);
    chk("async_count", 32'(bus.count), 32'd0);
    chk("async_ovf", 32'(bus.overflow), 32'd0);
    chk("async_dc", 32'(bus.drop_count), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_pc = 32'h1234; bus.wb_rd = 4'd7; bus.wb_data = 32'hCAFE0001;
    tick();
    chk("post_rst_stamp", 32'(bus.trace_stamp), 32'h0);
    chk("post_rst_data", bus.trace_data, 32'hCAFE0001);
    chk("post_rst_rd", 32'(bus.trace_rd), 32'd7);

    // Randomized traffic: slow reader then fast reader
    for (int i = 0; i < 600; i++) begin
      bus.wb_valid     = ($urandom % 4) != 0;
      bus.trace_ready  = (i < 300) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      bus.clr_overflow = ($urandom % 32) == 0;
      rand_fields();
      tick();
    end

    bus.wb_valid = 1'b0; bus.trace_ready = 1'b0; bus.clr_overflow = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
